// File: rtl/pbus_irq_gateway.sv
// pbus_irq_gateway: synchronises PBUS interrupt lines and turns them into PLIC gateway requests.
module pbus_irq_gateway #(
    parameter int                 NUM_SRC     = 4,
    parameter int                 NUM_LINES   = 32,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [NUM_SRC-1:0] EDGE_MASK   = 4'b0110,
    parameter int                 EDGE_CNT_W  = 3
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic [NUM_SRC-1:0]           irq_i,
    input  logic                         claim_valid_i,
    input  logic [$clog2(NUM_LINES)-1:0] claim_id_i,
    input  logic                         complete_valid_i,
    input  logic [$clog2(NUM_LINES)-1:0] complete_id_i,
    output logic [NUM_LINES-1:0]         plic_irq_o,
    output logic [NUM_SRC-1:0]           edge_ovf_o
);
    localparam int IDW = $clog2(NUM_LINES);
    typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, INFLIGHT = 2'd2} state_t;
    logic [NUM_SRC-1:0] w_assert;
    assign plic_irq_o = NUM_LINES'({w_assert, 1'b0});
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        localparam logic [IDW-1:0] ID = IDW'(i + 1);
        localparam bit IS_EDGE = EDGE_MASK[i];
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   r_prev;
        logic [EDGE_CNT_W-1:0]  r_cnt;
        logic                   r_ovf;
        state_t                 r_state;
        state_t                 w_next;
        logic w_s, w_rise, w_go, w_claim, w_done, w_inc, w_dec;
        assign w_s     = r_sync[SYNC_STAGES-1];
        assign w_rise  = w_s & ~r_prev;
        assign w_go    = (r_state == IDLE) && (IS_EDGE ? (w_rise || r_cnt != '0) : w_s);
        assign w_claim = (r_state == ASSERT) && claim_valid_i && (claim_id_i == ID);
        assign w_done  = (r_state == INFLIGHT) && complete_valid_i && (complete_id_i == ID);
        // A rise in IDLE is consumed directly by the request, so it never touches the count.
        assign w_inc   = IS_EDGE && w_rise && !w_go;
        assign w_dec   = IS_EDGE && w_go && !w_rise;
        always_comb begin
            w_next = r_state;
            w_next = w_go ? ASSERT : w_claim ? INFLIGHT : w_done ? IDLE : r_state;
        end
        always_ff @(posedge clock_i) begin
            if (reset_i) begin
                r_sync  <= '0;
                r_prev  <= 1'b0;
                r_cnt   <= '0;
                r_ovf   <= 1'b0;
                r_state <= IDLE;
            end else begin
                r_sync  <= SYNC_STAGES'({r_sync, irq_i[i]});
                r_prev  <= w_s;
                r_state <= w_next;
                if (w_inc && r_cnt == '1)
                    r_ovf <= 1'b1;
                else if (w_inc)
                    r_cnt <= r_cnt + 1'b1;
                else if (w_dec)
                    r_cnt <= r_cnt - 1'b1;
            end
        end
        assign w_assert[i]   = (r_state == ASSERT);
        assign edge_ovf_o[i] = r_ovf;
    end
endmodule

// File: tb/tb_pbus_irq_gateway.sv
// tb_pbus_irq_gateway: directed scenarios plus random traffic against a request-counting reference model.
module tb_pbus_irq_gateway;
    localparam int NS = 4;
    localparam int NL = 32;
    localparam int SS = 2;
    localparam logic [NS-1:0] EDGES = 4'b0110;
    localparam int CNT_MAX = 7;

    logic          clock_i = 1'b0;
    logic          reset_i = 1'b1;
    logic [NS-1:0] irq_i = '0;
    logic          claim_valid_i = 1'b0;
    logic [4:0]    claim_id_i = '0;
    logic          complete_valid_i = 1'b0;
    logic [4:0]    complete_id_i = '0;
    logic [NL-1:0] plic_irq_o;
    logic [NS-1:0] edge_ovf_o;

    pbus_irq_gateway dut (
        .clock_i(clock_i), .reset_i(reset_i), .irq_i(irq_i),
        .claim_valid_i(claim_valid_i), .claim_id_i(claim_id_i),
        .complete_valid_i(complete_valid_i), .complete_id_i(complete_id_i),
        .plic_irq_o(plic_irq_o), .edge_ovf_o(edge_ovf_o)
    );

    always #5 clock_i = ~clock_i;

    // Model: per source, whether it is waiting/requesting/being served, how many
    // edges are owed to the PLIC, and a delay line standing for the synchroniser.
    int checks = 0;
    int failures = 0;
    int m_phase [NS];
    int m_owed [NS];
    bit m_lost [NS];
    bit m_seen [NS];
    bit m_line [NS][$];
    int rises [NS];
    bit last_obs [NS];

    function automatic void model_reset();
        for (int i = 0; i < NS; i++) begin
            m_phase[i] = 0;
            m_owed[i] = 0;
            m_lost[i] = 0;
            m_seen[i] = 0;
            m_line[i].delete();
            for (int k = 0; k < SS; k++) m_line[i].push_back(1'b0);
        end
    endfunction

    function automatic void model_step();
        for (int i = 0; i < NS; i++) begin
            bit lvl, rise, start;
            lvl   = m_line[i][0];
            rise  = lvl && !m_seen[i];
            start = (m_phase[i] == 0) && (EDGES[i] ? (rise || m_owed[i] > 0) : lvl);
            if (start) begin
                m_phase[i] = 1;
                if (EDGES[i] && !rise) m_owed[i]--;
            end else if (m_phase[i] == 1 && claim_valid_i && int'(claim_id_i) == i + 1)
                m_phase[i] = 2;
            else if (m_phase[i] == 2 && complete_valid_i && int'(complete_id_i) == i + 1)
                m_phase[i] = 0;
            if (EDGES[i] && rise && !start) begin
                if (m_owed[i] == CNT_MAX) m_lost[i] = 1;
                else m_owed[i]++;
            end
            m_seen[i] = lvl;
            m_line[i].push_back(irq_i[i]);
            void'(m_line[i].pop_front());
        end
    endfunction

    function automatic logic [NL-1:0] exp_plic();
        logic [NL-1:0] v = '0;
        for (int i = 0; i < NS; i++) v[i+1] = (m_phase[i] == 1);
        return v;
    endfunction

    function automatic logic [NS-1:0] exp_ovf();
        logic [NS-1:0] v = '0;
        for (int i = 0; i < NS; i++) v[i] = m_lost[i];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        if (reset_i) model_reset(); else model_step();
        #1;
        chk("plic_model", plic_irq_o, exp_plic());
        chk("ovf_model", 32'(edge_ovf_o), 32'(exp_ovf()));
        for (int i = 0; i < NS; i++) begin
            if (plic_irq_o[i+1] && !last_obs[i]) rises[i]++;
            last_obs[i] = plic_irq_o[i+1];
        end
    endtask

    task automatic claim(input int id);
        claim_valid_i = 1'b1; claim_id_i = 5'(id);
        tick();
        claim_valid_i = 1'b0;
    endtask

    task automatic complete(input int id);
        complete_valid_i = 1'b1; complete_id_i = 5'(id);
        tick();
        complete_valid_i = 1'b0;
    endtask

    task automatic pulse(input int src);
        irq_i[src] = 1'b1; tick();
        irq_i[src] = 1'b0; tick();
    endtask

    initial begin
        logic [NL-1:0] snap;
        model_reset();
        for (int i = 0; i < NS; i++) begin rises[i] = 0; last_obs[i] = 0; end
        // T1 reset with all sources high
        irq_i = 4'hF;
        repeat (3) begin tick(); chk("t1_reset_plic", plic_irq_o, 32'd0); end
        reset_i = 1'b0;
        tick(); tick();
        chk("t1_early_line1", 32'(plic_irq_o[1]), 32'd0);
        tick();
        chk("t1_line1", 32'(plic_irq_o[1]), 32'd1);
        chk("t1_line4", 32'(plic_irq_o[4]), 32'd1);
        irq_i = '0;
        repeat (3) tick();
        for (int id = 1; id <= 4; id++) begin claim(id); complete(id); end
        repeat (3) tick();
        chk("t1_drained", plic_irq_o, 32'd0);
        // T2 level UART
        irq_i[3] = 1'b1;
        repeat (3) tick();
        chk("t2_assert", 32'(plic_irq_o[4]), 32'd1);
        claim(4);
        chk("t2_claimed", 32'(plic_irq_o[4]), 32'd0);
        complete(4);
        chk("t2_idle", 32'(plic_irq_o[4]), 32'd0);
        tick();
        chk("t2_reassert", 32'(plic_irq_o[4]), 32'd1);
        claim(4);
        irq_i[3] = 1'b0;
        repeat (3) tick();
        complete(4);
        repeat (2) tick();
        chk("t2_dropped", 32'(plic_irq_o[4]), 32'd0);
        // T3 edge burst on TIM0 while line 2 is in flight
        pulse(1); tick();
        chk("t3_first", 32'(plic_irq_o[2]), 32'd1);
        claim(2);
        repeat (3) pulse(1);
        rises[1] = 0;
        repeat (3) begin complete(2); tick(); claim(2); end
        complete(2);
        repeat (5) tick();
        chk("t3_reasserts", 32'(rises[1]), 32'd3);
        chk("t3_quiet", 32'(plic_irq_o[2]), 32'd0);
        // T4 saturation on TIM1
        pulse(2); tick(); claim(3);
        repeat (9) pulse(2);
        repeat (2) tick();
        chk("t4_cnt", 32'(dut.g_src[2].r_cnt), 32'(m_owed[2]));
        chk("t4_cnt_sat", 32'(dut.g_src[2].r_cnt), 32'd7);
        chk("t4_ovf", 32'(edge_ovf_o[2]), 32'd1);
        rises[2] = 0;
        repeat (7) begin complete(3); tick(); claim(3); end
        complete(3);
        repeat (5) tick();
        chk("t4_reasserts", 32'(rises[2]), 32'd7);
        chk("t4_ovf_sticky", 32'(edge_ovf_o[2]), 32'd1);
        // T5 illegal handshakes
        pulse(1); tick();
        snap = plic_irq_o;
        chk("t5_setup", 32'(plic_irq_o[2]), 32'd1);
        claim(0); claim(5); claim(31); complete(2); claim(1);
        chk("t5_unchanged", plic_irq_o, snap);
        claim(2); complete(2);
        // T6 simultaneous claim/complete with a rise while leaving IDLE
        pulse(2); tick(); claim(3);
        pulse(2); tick();
        chk("t6_stored", 32'(dut.g_src[2].r_cnt), 32'd1);
        pulse(1); tick();
        irq_i[2] = 1'b1; tick();
        claim_valid_i = 1'b1; claim_id_i = 5'd2;
        complete_valid_i = 1'b1; complete_id_i = 5'd3;
        tick();
        claim_valid_i = 1'b0; complete_valid_i = 1'b0;
        chk("t6_claimed", 32'(plic_irq_o[2]), 32'd0);
        chk("t6_completed", 32'(plic_irq_o[3]), 32'd0);
        tick();
        chk("t6_reassert", 32'(plic_irq_o[3]), 32'd1);
        chk("t6_cnt_kept", 32'(dut.g_src[2].r_cnt), 32'd1);
        irq_i[2] = 1'b0;
        // Random traffic with one mid-run reset
        for (int n = 0; n < 3000; n++) begin
            irq_i = 4'($urandom);
            claim_valid_i = ($urandom_range(0, 2) != 0);
            claim_id_i = 5'($urandom_range(0, 6));
            complete_valid_i = ($urandom_range(0, 2) != 0);
            complete_id_i = 5'($urandom_range(0, 6));
            reset_i = (n >= 1500 && n < 1502);
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
